// File: rtl/uart_tx_word_arbiter.sv
// Round-robin arbiter that hands one requester's word at a time to a byte-wide
// UART transmitter, streaming the latched word MSB byte first with backpressure.
module uart_tx_word_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_tx_valid,
  output logic [7:0]                    o_tx_data,
  input  logic                          i_tx_ready,
  output logic                          o_busy,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_word_done
);

  localparam int BYTES = WORD_WIDTH / 8;
  localparam int IW    = $clog2(NUM_REQ);
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  r_state, w_state_nxt;
  logic [WORD_WIDTH-1:0]   r_shreg;
  logic [BCW-1:0]          r_byte_cnt;
  logic [IW-1:0]           r_last_grant;
  logic [NUM_REQ-1:0]      r_grant;
  logic                    r_busy;
  logic                    r_word_done;

  logic [NUM_REQ-1:0][WORD_WIDTH-1:0] w_words;
  logic                    w_pick_any;
  logic [IW-1:0]           w_pick_idx;
  logic [NUM_REQ-1:0]      w_pick_oh;
  logic                    w_hs;
  logic                    w_tx_fire;
  logic                    w_last_byte;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_words[g] = i_req_data[g*WORD_WIDTH +: WORD_WIDTH];
  end

  // Rotating search starting one past the previous winner, wrapping at NUM_REQ.
  always_comb begin
    logic [IW-1:0] v_idx;
    w_pick_any = 1'b0;
    w_pick_idx = '0;
    v_idx      = r_last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v_idx == IW'(NUM_REQ-1)) v_idx = '0;
      else                         v_idx = v_idx + 1'b1;
      if (!w_pick_any && i_req_valid[v_idx]) begin
        w_pick_any = 1'b1;
        w_pick_idx = v_idx;
      end
    end
  end

  assign w_pick_oh   = w_pick_any ? (NUM_REQ'(1) << w_pick_idx) : '0;
  assign o_req_ready = (r_state == IDLE && i_rst_n) ? w_pick_oh : '0;
  assign w_hs        = |(i_req_valid & o_req_ready);
  assign w_tx_fire   = (r_state == SEND) && i_tx_ready;
  assign w_last_byte = (r_byte_cnt == BCW'(BYTES-1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = SEND;
      SEND:    if (w_tx_fire && w_last_byte) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shreg      <= '0;
      r_byte_cnt   <= '0;
      r_last_grant <= IW'(NUM_REQ-1);
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_word_done  <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      if (w_hs) begin
        r_shreg      <= w_words[w_pick_idx];
        r_grant      <= w_pick_oh;
        r_last_grant <= w_pick_idx;
        r_byte_cnt   <= '0;
        r_busy       <= 1'b1;
      end else if (w_tx_fire) begin
        r_shreg <= r_shreg << 8;
        if (w_last_byte) begin
          r_busy      <= 1'b0;
          r_grant     <= '0;
          r_word_done <= 1'b1;
        end else begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end
    end
  end

  // Byte lane is forced to zero outside SEND so idle cycles never leak stale data.
  assign o_tx_valid  = (r_state == SEND);
  assign o_tx_data   = o_tx_valid ? r_shreg[WORD_WIDTH-1 -: 8] : 8'h00;
  assign o_busy      = r_busy;
  assign o_grant     = r_grant;
  assign o_word_done = r_word_done;

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Randomized and directed bench for uart_tx_word_arbiter against a
// transaction-level model (byte queue per granted word, rotation rule).
module tb_uart_tx_word_arbiter;
  localparam int NR = 4;
  localparam int WW = 64;
  localparam int NB = WW / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*WW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;
  logic             busy;
  logic [NR-1:0]    grant;
  logic             word_done;

  always #5 clk = ~clk;

  uart_tx_word_arbiter #(.NUM_REQ(NR), .WORD_WIDTH(WW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_tx_valid(tx_valid), .o_tx_data(tx_data),
    .i_tx_ready(tx_ready), .o_busy(busy), .o_grant(grant), .o_word_done(word_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // model state
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_last = NR-1;
  int         m_owner = 0;
  logic [7:0] m_q[$];

  // observation logs
  int cyc_n = 0;
  int win_log[$];
  int hs_n[NR];
  int hs_cyc[NR];
  int done_cnt, tv_cnt, first_done;

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic clr();
    win_log.delete();
    for (int i = 0; i < NR; i++) begin hs_n[i] = 0; hs_cyc[i] = -1; end
    done_cnt = 0; tv_cnt = 0; first_done = -1;
  endtask

  task automatic model();
    int w;
    logic [NR-1:0] e_rdy, e_gnt;
    logic [7:0]    e_data;
    cyc_n++;
    e_rdy = '0; e_gnt = '0; e_data = 8'h00;
    if (!m_busy && rst_n) begin
      w = rr_pick(req_valid, m_last);
      if (w >= 0) e_rdy[w] = 1'b1;
    end
    if (m_busy) begin e_gnt[m_owner] = 1'b1; e_data = m_q[0]; end
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("tx_valid",  64'(tx_valid),  64'(m_busy));
    chk("tx_data",   64'(tx_data),   64'(e_data));
    chk("busy",      64'(busy),      64'(m_busy));
    chk("grant",     64'(grant),     64'(e_gnt));
    chk("word_done", 64'(word_done), 64'(m_done));
    if (tx_valid) tv_cnt++;
    if (word_done) begin
      done_cnt++;
      if (first_done < 0) first_done = cyc_n;
    end
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) begin
        hs_n[i]++;
        win_log.push_back(i);
        if (hs_cyc[i] < 0) hs_cyc[i] = cyc_n;
      end
    // advance to the state after the coming edge
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_last = NR-1; m_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (tx_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin m_busy = 1'b0; m_done = 1'b1; end
        end
      end else begin
        w = rr_pick(req_valid, m_last);
        if (w >= 0) begin
          m_busy = 1'b1; m_last = w; m_owner = w;
          for (int b = 0; b < NB; b++) m_q.push_back(req_data[w*WW + WW-1 - 8*b -: 8]);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0;
    step();
    rst_n = 1'b1;
  endtask

  int wc;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; tx_ready = 1'b1;
    clr();
    @(posedge clk); #1;
    step();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_tx_data", 64'(tx_data), 64'd0);
    rst_n = 1'b1;

    // single word, no backpressure
    clr();
    req_data[0 +: WW] = 64'h0123456789ABCDEF;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (10) step();
    chk("p1_hs0", 64'(hs_n[0]), 64'd1);
    chk("p1_bytes", 64'(tv_cnt), 64'(NB));
    chk("p1_done", 64'(done_cnt), 64'd1);

    // backpressure: three stall cycles ahead of every accepted byte
    clr();
    tx_ready = 1'b0;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    wc = 0;
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      if (tx_valid) wc++;
      tx_ready = tx_valid && (wc % 4 == 0);
      step();
    end
    tx_ready = 1'b1;
    step();
    chk("p2_done", 64'(done_cnt), 64'd1);
    chk("p2_send_cycles", 64'(tv_cnt), 64'd32);

    // round-robin fairness from reset
    do_reset();
    clr();
    for (int i = 0; i < NR; i++) req_data[i*WW +: WW] = {8{8'(i+1)}};
    req_valid = 4'b1111;
    repeat (40) step();
    req_valid = '0;
    repeat (12) step();
    chk("p3_nwin", 64'(win_log.size()), 64'd5);
    if (win_log.size() == 5) begin
      chk("p3_win0", 64'(win_log[0]), 64'd0);
      chk("p3_win1", 64'(win_log[1]), 64'd1);
      chk("p3_win2", 64'(win_log[2]), 64'd2);
      chk("p3_win3", 64'(win_log[3]), 64'd3);
      chk("p3_win4", 64'(win_log[4]), 64'd0);
    end

    // rotation priority after requester 2 was last served
    do_reset();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (10) step();
    clr();
    req_valid = 4'b1010;
    repeat (12) step();
    req_valid = '0;
    repeat (12) step();
    chk("p4_nwin", 64'(win_log.size()), 64'd2);
    if (win_log.size() == 2) begin
      chk("p4_first", 64'(win_log[0]), 64'd3);
      chk("p4_second", 64'(win_log[1]), 64'd1);
    end
    chk("p4_never0", 64'(hs_n[0]), 64'd0);
    chk("p4_never2", 64'(hs_n[2]), 64'd0);

    // reset after byte 3 is accepted, then requester 1 sends cleanly
    clr();
    req_data[0 +: WW] = {$urandom, $urandom};
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("p5_busy_after_rst", 64'(busy), 64'd0);
    chk("p5_txv_after_rst", 64'(tx_valid), 64'd0);
    chk("p5_grant_after_rst", 64'(grant), 64'd0);
    req_data[1*WW +: WW] = {$urandom, $urandom};
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    repeat (10) step();
    chk("p5_done", 64'(done_cnt), 64'd1);
    chk("p5_hs1", 64'(hs_n[1]), 64'd1);

    // request from 2 arrives mid-send of requester 0
    clr();
    req_data[0 +: WW]    = {$urandom, $urandom};
    req_data[2*WW +: WW] = {$urandom, $urandom};
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0100;
    repeat (12) step();
    req_valid = '0;
    repeat (12) step();
    chk("p6_hs2_at_done", 64'(hs_cyc[2]), 64'(first_done));
    chk("p6_hs2_seen", 64'(hs_n[2] > 0), 64'd1);

    // random traffic with backpressure, data churn and occasional reset
    clr();
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      req_valid = NR'($urandom);
      tx_ready  = ($urandom_range(0, 3) != 0);
      req_data[$urandom_range(0, NR-1)*WW +: WW] = {$urandom, $urandom};
      step();
    end
    rst_n = 1'b1; req_valid = '0; tx_ready = 1'b1;
    repeat (12) step();
    chk("p7_progress", 64'(done_cnt > 20), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_word_arbiter.md
# uart_tx_word_arbiter

Shares one byte-wide UART transmitter between several word-producing requesters. Each requester offers a full word. The block grants one requester at a time in round-robin order, latches its word, and streams the word MSB byte first into the UART TX byte interface with full backpressure. It sits between the measurement/debug word sources and the UART TX core, and replaces ad-hoc word-to-byte splitting that ignores transmitter readiness.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WORD_WIDTH, 64, bits per requester word; must be a multiple of 8
- BYTES (local), WORD_WIDTH/8, bytes per word
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  NUM_REQ  requester i has a word pending
- req_data  input  NUM_REQ*WORD_WIDTH  word of requester i in bits [i*WORD_WIDTH +: WORD_WIDTH]
- req_ready  output  NUM_REQ  one-hot accept; word i transfers on req_valid[i] & req_ready[i]
- tx_valid  output  1  tx_data holds a byte for the UART
- tx_data  output  8  byte to transmit
- tx_ready  input  1  UART accepts the byte this cycle
- busy  output  1  a word is latched and not yet fully sent
- grant  output  NUM_REQ  one-hot owner of the latched word; 0 when idle
- word_done  output  1  one-cycle pulse after the last byte of a word is accepted

## Operation
- FSM states: IDLE, SEND.
- IDLE: req_ready is the combinational round-robin pick among req_valid. The search starts at last_grant+1 and wraps modulo NUM_REQ. req_ready = 0 if no request is valid or rst_n = 0.
- On a handshake in IDLE:
  - Latch req_data of the winner into shift register shreg.
  - grant <= winner one-hot; last_grant <= winner index.
  - byte_cnt <= 0; busy <= 1; state <= SEND.
- SEND:
  - tx_valid = 1; tx_data = shreg[WORD_WIDTH-1 -: 8].
  - req_ready = 0 for all requesters.
- On tx_valid & tx_ready:
  - shreg shifts left 8, zero-filled; byte_cnt increments.
  - If byte_cnt == BYTES-1: state <= IDLE, busy <= 0, grant <= 0, word_done <= 1 for one cycle, tx_valid drops.
- While tx_ready = 0, tx_valid and tx_data hold stable (no retraction, no byte change).
- Arbitration ignores requesters while in SEND. req_valid changes during SEND have no effect. A latched word is unaffected by later req_data changes.
- byte_cnt width is clog2(BYTES), minimum 1. No wrap beyond BYTES-1.

## Timing
- Reset values:
  - tx_valid = 0, tx_data = 0x00, busy = 0, grant = 0, word_done = 0, req_ready = 0.
  - state = IDLE, shreg = 0, byte_cnt = 0.
  - last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
- Reset mid-SEND discards the latched word:
  - The cycle after rst_n is sampled low, all outputs are at reset values.
  - No word_done is produced for the discarded word.
- Latency: handshake at cycle T gives tx_valid = 1 with byte 0 at T+1.
- With tx_ready held high, bytes issue on T+1..T+BYTES. word_done is high and state is IDLE at T+BYTES+1.
- A new word can be accepted in that same T+BYTES+1 cycle, so the steady-state gap is one idle cycle per word.
- A requester wins at most once per word slot.
- Simultaneous requests are resolved strictly by rotation from last_grant. A requester that stays valid is served within NUM_REQ words.
- tx_data is 0x00 whenever tx_valid = 0.

## Test plan
- Single word, no backpressure:
  - Stimulus: req_valid = 0001, word0 = 0x0123456789ABCDEF, tx_ready = 1.
  - Response: req_ready[0] pulses once. tx_data = 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles. word_done pulses the following cycle. grant = 0001 during the send.
- Backpressure:
  - Stimulus: same word; tx_ready low for 3 cycles before each byte.
  - Response: each byte is held stable across its wait cycles. The byte order is unchanged. Total send takes 32 cycles after the first tx_valid.
- Round-robin fairness:
  - Stimulus: all four requesters valid continuously; word i = {8{i+1 as byte}}.
  - Response: grant order 0,1,2,3,0. Byte streams are 0x01×8, 0x02×8, etc., with one idle cycle between words.
- Rotation priority:
  - Stimulus: last served = 2; then req_valid = 1010.
  - Response: requester 3 granted first, then requester 1. req_ready is never asserted to 0 or 2.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 after byte 3 of a word is accepted; release; requester 1 valid.
  - Response: tx_valid = 0, busy = 0, grant = 0 the next cycle. No word_done for the aborted word. After release, requester 1's word is sent from its MSB byte.
- Request during SEND:
  - Stimulus: requester 2 asserts req_valid while requester 0's word is sending.
  - Response: req_ready stays 0 until IDLE. Requester 2 is granted in the word_done cycle.
